// File: rtl/fft_delay_pkg.sv
// fft_delay_pkg: shared depth-field sizing, depth clamping and the stored {vld, data} entry.
package fft_delay_pkg;

    localparam int W_DEF    = 16;
    localparam int DMAX_DEF = 64;

    typedef struct packed {
        logic              vld;
        logic [W_DEF-1:0]  data;
    } entry_t;

    function automatic int depth_width(input int dmax);
        return $clog2(dmax + 1);
    endfunction

    function automatic int clamp_depth(input int req, input int dmax);
        return (req < 1) ? 1 : (req > dmax) ? dmax : req;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: one write port and one synchronous read port; the read returns the
// pre-write contents when both ports hit the same address on the same edge.
module sdp_ram #(
    parameter int DEPTH = 63,
    parameter int WD    = 17,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [WD-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [WD-1:0] rdata_o
);

    logic [WD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/prog_delay_line.sv
// prog_delay_line: run-time programmable delay of {vld, data} through a circular buffer,
// with stall enable, flush on reprogram and fill-count masking of unwritten entries.
module prog_delay_line
    import fft_delay_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int DMAX = DMAX_DEF,
    parameter int DW   = depth_width(DMAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_load,
    input  logic [DW-1:0] cfg_depth,
    input  logic          en,
    input  logic          vld_in,
    input  logic [W-1:0]  d_in,
    output logic          vld_out,
    output logic [W-1:0]  d_out,
    output logic [DW-1:0] depth
);

    localparam int AW = (DMAX > 2) ? $clog2(DMAX - 1) : 1;

    logic          run, one;
    logic [DW-1:0] depth_q, depth_d, fc_q, fc_d;
    logic [AW-1:0] wp_q, wp_d;
    logic          ok_q, ok_d, zero_q, zero_d;
    logic [W:0]    byp_q, byp_d, rdata, out_e;

    assign run = en & ~cfg_load;
    assign one = depth_q == DW'(1);

    // ok_q records whether the entry just read had been written since the last flush
    always_comb begin
        depth_d = cfg_load ? DW'(clamp_depth(int'(cfg_depth), DMAX)) : depth_q;
        fc_d    = cfg_load ? '0 : !run ? fc_q : (fc_q == depth_q - DW'(1)) ? fc_q : fc_q + DW'(1);
        wp_d    = cfg_load ? '0 : (!run || one) ? wp_q : (DW'(wp_q) == depth_q - DW'(2)) ? '0 : wp_q + AW'(1);
        ok_d    = cfg_load ? 1'b0 : run ? (fc_q == depth_q - DW'(1)) : ok_q;
        zero_d  = cfg_load ? 1'b1 : run ? 1'b0 : zero_q;
        byp_d   = (run && one) ? {vld_in, d_in} : byp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= DW'(DMAX);
            fc_q    <= '0;
            wp_q    <= '0;
            ok_q    <= 1'b0;
            zero_q  <= 1'b1;
            byp_q   <= '0;
        end else begin
            depth_q <= depth_d;
            fc_q    <= fc_d;
            wp_q    <= wp_d;
            ok_q    <= ok_d;
            zero_q  <= zero_d;
            byp_q   <= byp_d;
        end
    end

    sdp_ram #(.DEPTH(DMAX - 1), .WD(W + 1), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (run & ~one),
        .waddr_i (wp_q),
        .wdata_i ({vld_in, d_in}),
        .re_i    (run & ~one),
        .raddr_i (wp_q),
        .rdata_o (rdata)
    );

    // the RAM read register doubles as the output stage; zero_q forces the flushed value
    assign out_e   = one ? byp_q : rdata;
    assign d_out   = zero_q ? '0 : out_e[W-1:0];
    assign vld_out = ok_q & out_e[W];
    assign depth   = depth_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: directed steps checked against a D-stage shift-register reference.
module tb_prog_delay_line;

    localparam int W    = 16;
    localparam int DMAX = 64;
    localparam int DW   = 7;

    logic          clk = 1'b0;
    logic          rst_n, cfg_load, en, vld_in;
    logic [DW-1:0] cfg_depth;
    logic [W-1:0]  d_in, d_out;
    logic          vld_out;
    logic [DW-1:0] depth;

    int total = 0;
    int bad   = 0;

    // reference: stage md-1 is the output; mk marks stages whose data is defined
    logic         mv [DMAX];
    logic [W-1:0] mdat [DMAX];
    logic         mk [DMAX];
    int           md;

    prog_delay_line #(.W(W), .DMAX(DMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_depth (cfg_depth),
        .en        (en),
        .vld_in    (vld_in),
        .d_in      (d_in),
        .vld_out   (vld_out),
        .d_out     (d_out),
        .depth     (depth)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flush(input int nd);
        md = nd;
        for (int i = 0; i < DMAX; i++) begin
            mv[i] = 1'b0;
            mk[i] = 1'b0;
            mdat[i] = '0;
        end
        mk[md-1] = 1'b1;
    endtask

    task automatic step(input logic e, input logic v, input logic [W-1:0] d,
                        input logic ld, input int cd);
        en = e; vld_in = v; d_in = d; cfg_load = ld; cfg_depth = DW'(cd);
        @(posedge clk);
        #1;
        if (ld) flush((cd < 1) ? 1 : (cd > DMAX) ? DMAX : cd);
        else if (e) begin
            for (int i = DMAX - 1; i > 0; i--) begin
                mv[i] = mv[i-1]; mdat[i] = mdat[i-1]; mk[i] = mk[i-1];
            end
            mv[0] = v; mdat[0] = d; mk[0] = 1'b1;
        end
        chk("depth", depth, md);
        chk("vld_out", vld_out, mv[md-1]);
        if (mk[md-1]) chk("d_out", d_out, mdat[md-1]);
        en = 1'b0; cfg_load = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b1; cfg_load = 1'b0; cfg_depth = '0; en = 1'b0; vld_in = 1'b0; d_in = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", d_out, 0);
        chk("rst_vld", vld_out, 0);
        chk("rst_depth", depth, 64);
        flush(DMAX);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step(0, 0, 0, 1, 4);
        chk("depth4", depth, 4);
        for (int k = 1; k <= 12; k++) begin
            step(1, 1, W'(k), 0, 0);
            if (k == 3) chk("d4_early", vld_out, 0);
            if (k == 4) chk("d4_first", d_out, 1);
            if (k == 5) chk("d4_second", d_out, 2);
        end

        step(0, 0, 0, 1, 5);
        n = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                n++;
                step(1, n != 3, W'(16'h100 + n), 0, 0);
            end else step(0, 1, 16'hdead, 0, 0);
            if (i == 8) chk("d5_first", d_out, 16'h101);
            if (i == 9) chk("d5_hold", d_out, 16'h101);
            if (i == 12) chk("d5_vld_gap", vld_out, 0);
        end

        step(0, 0, 0, 1, 1);
        for (int k = 1; k <= 6; k++) begin
            step(1, 1, W'(16'h200 + k), 0, 0);
            if (k == 1) chk("d1_lat", d_out, 16'h201);
        end

        step(0, 0, 0, 1, 64);
        for (int k = 1; k <= 192; k++) begin
            step(1, 1, W'(16'h300 + k), 0, 0);
            if (k == 63) chk("d64_early", vld_out, 0);
            if (k == 64) chk("d64_first", d_out, 16'h301);
            if (k == 192) chk("d64_last", d_out, 16'h381);
        end

        step(0, 0, 0, 1, 8);
        for (int k = 1; k <= 20; k++) step(1, 1, W'(16'h400 + k), 0, 0);
        step(1, 1, 16'hbeef, 1, 3);
        chk("ld3_dout", d_out, 0);
        chk("ld3_depth", depth, 3);
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, W'(16'h500 + k), 0, 0);
            if (k == 2) chk("d3_early", vld_out, 0);
            if (k == 3) chk("d3_first", d_out, 16'h501);
        end

        step(0, 0, 0, 1, 0);
        chk("clamp_lo", depth, 1);
        step(0, 0, 0, 1, DMAX + 5);
        chk("clamp_hi", depth, 64);

        step(0, 0, 0, 1, 4);
        for (int k = 1; k <= 10; k++) step(1, 1, W'(16'h600 + k), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout", d_out, 0);
        chk("arst_vld", vld_out, 0);
        chk("arst_depth", depth, 64);
        flush(DMAX);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            step(1, 1, W'(16'h700 + k), 0, 0);
            if (k == 63) chk("arst_early", vld_out, 0);
            if (k == 64) chk("arst_first", d_out, 16'h701);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
